// File: rtl/spi_pkg.sv
// Shared SPI constants and types for the MISO serializer path and its feeders.
// Kept small so a future MOSI receiver can import the same definitions.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W    = 8;
    localparam int unsigned SPI_BIT_CNT_W = 3;

    typedef logic [SPI_BYTE_W-1:0]    spi_byte_t;
    typedef logic [SPI_BIT_CNT_W-1:0] spi_bit_cnt_t;

    localparam spi_byte_t    IDLE_BYTE_DEFAULT = 8'hFF;
    localparam spi_bit_cnt_t SPI_LAST_BIT      = spi_bit_cnt_t'(SPI_BYTE_W - 1);

    function automatic logic spi_is_last_bit(input spi_bit_cnt_t cnt);
        return cnt == SPI_LAST_BIT;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, followed by one edge register.
// level_o, rise_o and fall_o are mutually aligned: all reflect the pin 3 clocks later.
module spi_in_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
        fall_d = ~sync_q & prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_tx_byte_feeder.sv
// Buffers bytes for the SPI slave MISO serializer and presents one stable byte per frame,
// advancing when the system-clock-domain SPI edge counter completes an 8-bit frame.
module spi_tx_byte_feeder
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter spi_byte_t   IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [SPI_BYTE_W-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    SLK,
    input  logic                    CS,
    input  logic                    underrun_clr,
    output logic [SPI_BYTE_W-1:0]   tx_byte,
    output logic                    frame_done,
    output logic                    underrun,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] LevelFull = LvlW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end

    logic slk_level, slk_rise, slk_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_in_sync u_slk_sync (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .async_i (SLK),
        .level_o (slk_level),
        .rise_o  (slk_rise),
        .fall_o  (slk_fall)
    );

    spi_in_sync u_cs_sync (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .async_i (CS),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    logic unused_slk;
    assign unused_slk = slk_level ^ slk_fall;

    spi_byte_t       mem_q [DEPTH];
    spi_byte_t       mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    spi_bit_cnt_t    bit_cnt_q, bit_cnt_d;
    spi_byte_t       tx_byte_q, tx_byte_d;
    logic            cur_valid_q, cur_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            underrun_q, underrun_d;

    logic fifo_empty;
    logic push, pop;
    logic cs_edge, frame_edge, frame_end, preload;

    assign in_ready   = level_q < LevelFull;
    assign fifo_empty = level_q == '0;
    assign push       = in_valid & in_ready;

    // Any CS transition restarts bit counting, so an edge coinciding with it is dropped.
    assign cs_edge    = cs_rise | cs_fall;
    assign frame_edge = slk_rise & cs_level & ~cs_edge;
    assign frame_end  = frame_edge & spi_is_last_bit(bit_cnt_q);
    assign preload    = ~cs_level & ~cur_valid_q & ~fifo_empty;
    assign pop        = (frame_end | preload) & ~fifo_empty;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (cs_edge) begin
            bit_cnt_d = '0;
        end else if (frame_edge) begin
            bit_cnt_d = bit_cnt_q + spi_bit_cnt_t'(1);
        end
    end

    always_comb begin
        tx_byte_d   = tx_byte_q;
        cur_valid_d = cur_valid_q;
        if (frame_end) begin
            tx_byte_d   = fifo_empty ? IDLE_BYTE : mem_q[rd_ptr_q];
            cur_valid_d = ~fifo_empty;
        end else if (preload) begin
            tx_byte_d   = mem_q[rd_ptr_q];
            cur_valid_d = 1'b1;
        end
    end

    // A frame that shipped IDLE_BYTE outranks a simultaneous clear.
    always_comb begin
        underrun_d = underrun_q;
        if (underrun_clr) begin
            underrun_d = 1'b0;
        end
        if (frame_end && !cur_valid_q) begin
            underrun_d = 1'b1;
        end
        frame_done_d = frame_end;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
        end
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            bit_cnt_q    <= '0;
            tx_byte_q    <= IDLE_BYTE;
            cur_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_byte_q    <= tx_byte_d;
            cur_valid_q  <= cur_valid_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    // Storage needs no reset: the pointers and level decide what is readable.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            mem_q <= mem_d;
        end
    end

    assign tx_byte    = tx_byte_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign level      = level_q;

endmodule

// File: doc/spi_tx_byte_feeder.md
# spi_tx_byte_feeder

Upstream feeder for the SPI slave MISO serializer. Accepts bytes from system logic over a valid/ready handshake and buffers them in a small FIFO. Presents one stable byte on its parallel output for each SPI frame, driving the serializer's bit7..bit0 inputs. Counts SPI clock edges in the system clock domain and advances to the next byte when each 8-bit frame completes.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- IDLE_BYTE, 8'hFF, byte presented when no buffered data is available
- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- in_data  in  8  byte to transmit, MSB first
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready on a CLK edge
- SLK  in  1  raw SPI clock from master, asynchronous to CLK
- CS  in  1  raw chip select, asynchronous to CLK; active-high, same polarity the serializer uses
- underrun_clr  in  1  clears underrun
- tx_byte  out  8  byte to serializer; tx_byte[7] drives bit7 … tx_byte[0] drives bit0
- frame_done  out  1  one-CLK pulse per completed 8-bit frame
- underrun  out  1  sticky: a frame completed carrying IDLE_BYTE
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- SLK and CS each pass through a 2-flop synchronizer, then an edge-detect register.
- Frame edge = synchronized SLK rising edge while synchronized CS = 1.
- 3-bit bit counter: +1 per frame edge; the edge taking it 7→0 completes a frame.
- CS rising or falling edge clears the counter. CS falling mid-frame aborts the frame: tx_byte is held, nothing is popped, and no frame_done pulse is issued.
- Internal flag cur_valid: 1 when tx_byte holds a FIFO byte, 0 when it holds IDLE_BYTE.
- Frame completion:
  - If cur_valid was 0, set underrun.
  - If the FIFO is non-empty, pop the head into tx_byte and set cur_valid = 1.
  - Otherwise load IDLE_BYTE and set cur_valid = 0.
  - Pulse frame_done.
- Idle preload: while synchronized CS = 0, cur_valid = 0 and the FIFO is non-empty, pop the head into tx_byte and set cur_valid = 1.
- tx_byte never changes while synchronized CS = 1, except at frame completion.
- in_ready = (level < DEPTH), combinational from the registered level.
- Push and pop in the same cycle: level unchanged, both take effect. Full plus pop: no push that cycle, because in_ready was 0.
- underrun_clr clears underrun. If it coincides with a set event, the set wins.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked separately, so full and empty are unambiguous.
- RST_N low mid-frame: all state is reset, including the counter. The partially sent byte is lost.

## Timing
- Reset values: tx_byte = IDLE_BYTE, cur_valid = 0, frame_done = 0, underrun = 0, level = 0, in_ready = 1 on the first cycle after reset. in_valid is ignored while RST_N = 0.
- SLK/CS pin edge → detected internally: 3 CLK cycles (2 sync + 1 edge register).
- 8th frame edge at pin → tx_byte updated and frame_done high: 4 CLK cycles.
- Push → byte visible in level: next CLK. Push into an empty FIFO with CS low and cur_valid = 0 → tx_byte loaded 2 CLK cycles after the push edge.
- Required clock ratio: f_CLK ≥ 8 × f_SLK, with SLK high and low phases each ≥ 3 CLK periods. This guarantees tx_byte settles before the next frame's first edge.

## Structure
- Package spi_pkg: SPI_BYTE_W = 8, SPI_BIT_CNT_W = 3, IDLE_BYTE_DEFAULT = 8'hFF. The serializer and a future MOSI receiver share these.
- Sub-module spi_in_sync: 2-flop synchronizer plus registered rise/fall pulses. Instantiated once for SLK and once for CS.
- FIFO storage, the counter and the control logic live inline in the top module.

## Test plan
- Reset, then push 8'hA5, 8'h3C with CS low → tx_byte = 8'hA5, level = 1, in_ready = 1.
- With CS high, 8 SLK pulses at ratio 10 → exactly one frame_done pulse; tx_byte = 8'h3C 4 CLK cycles after the 8th edge; tx_byte stable throughout the frame.
- Push 4 bytes with DEPTH = 4 → level = 4, in_ready = 0, a 5th in_valid is not accepted. Complete one frame → level drops to 3 and in_ready returns to 1. Simultaneous push/pop at level 3 → level stays 3.
- Empty FIFO, cur_valid = 0, run a full frame → tx_byte = 8'hFF, underrun = 1 and stays set. Pulse underrun_clr → underrun = 0. A clear coinciding with a new underrun event → underrun remains 1.
- 5 SLK pulses, then CS low → no frame_done, tx_byte unchanged, level unchanged. Next CS high plus 8 pulses → a full frame completes normally.
- Assert RST_N = 0 for 1 cycle after 3 frame edges → all outputs return to their reset values. The next 8 edges are counted from 0.
